nes_clk_en: RTL and testbench

Clock-enable sequencer that consumes one divided clock from the clock generator and derives the NES timing strobes from it. It produces single-cycle enables for the PPU dot, the CPU cycle (one per `CPU_RATIO` dots) and the APU (one per two CPU cycles), and counts CPU cycles. A debug run/halt/single-step control freezes the CPU/PPU/APU timebase on a CPU-cycle boundary. All downstream NES cores run on `clk` and gate their logic with these enables; they use no derived clocks.

---
 rtl/nes_clk_pkg.sv | 19 +
 rtl/ce_mod_counter.sv | 31 +++
 rtl/nes_clk_en.sv | 119 +++++++++++
 tb/tb_nes_clk_en.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_clk_pkg.sv
// Shared types and default ratios for the NES clock-enable sequencer.
// The HALT/STEP debug control is built only when NES_CLK_STEP_EN is defined.
package nes_clk_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } nes_clk_state_e;

  localparam int NES_PPU_DIV   = 4;
  localparam int NES_CPU_RATIO = 3;

  // Counter width for a modulo-n count; a 1-bit floor keeps n<=2 legal.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ce_mod_counter.sv
// Generic modulo-N counter: advances on adv, wraps N-1 -> 0.
// Exposes terminal-count and zero decodes of the registered count.
module ce_mod_counter
  import nes_clk_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_w(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  output logic tc,
  output logic zero
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc   = (cnt_q == W'(N - 1));
  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (adv) cnt_d = tc ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nes_clk_en.sv
// NES timing strobes (PPU dot / CPU cycle / APU) derived from a single clk.
// Define NES_CLK_STEP_EN to build the run/halt/single-step debug control.
module nes_clk_en
  import nes_clk_pkg::*;
#(
  parameter int PPU_DIV   = NES_PPU_DIV,
  parameter int CPU_RATIO = NES_CPU_RATIO,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             step_req,
  output logic             ppu_ce,
  output logic             cpu_ce,
  output logic             apu_ce,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cpu_cycles
);

  if (PPU_DIV < 2)   begin : g_bad_div   $error("PPU_DIV must be >= 2");   end
  if (CPU_RATIO < 2) begin : g_bad_ratio $error("CPU_RATIO must be >= 2"); end

  logic adv;
  logic div_tc, div_zero;
  logic ph_tc, ph_zero;
  logic boundary;
  logic apu_ph_q, apu_ph_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  ce_mod_counter #(.N(PPU_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .tc    (div_tc),
    .zero  (div_zero)
  );

  ce_mod_counter #(.N(CPU_RATIO)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (ppu_ce),
    .tc    (ph_tc),
    .zero  (ph_zero)
  );

  assign boundary = div_zero && ph_zero;
  assign ppu_ce   = adv && div_tc;
  assign cpu_ce   = ppu_ce && ph_tc;
  assign apu_ce   = cpu_ce && apu_ph_q;

  always_comb begin
    apu_ph_d = apu_ph_q ^ cpu_ce;
    cyc_d    = cyc_q + {{(CNT_W-1){1'b0}}, cpu_ce};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apu_ph_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      apu_ph_q <= apu_ph_d;
      cyc_q    <= cyc_d;
    end
  end

  assign cpu_cycles = cyc_q;

`ifdef NES_CLK_STEP_EN
  nes_clk_state_e state_q, state_d;
  logic           halted_q, halted_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // A halt only lands on a boundary, so a CPU cycle in flight always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (halt && boundary) state_d = ST_HALT;
      ST_HALT: begin
        if (step_req)  state_d = ST_STEP;
        else if (!halt) state_d = ST_RUN;
      end
      ST_STEP: if (cpu_ce) state_d = halt ? ST_HALT : ST_RUN;
      default: state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_comb begin
    adv = 1'b0;
    case (state_q)
      ST_RUN:  adv = !(halt && boundary);
      ST_STEP: adv = 1'b1;
      default: adv = 1'b0;
    endcase
  end

  assign step_done = (state_q == ST_STEP) && cpu_ce;
  assign halted    = halted_q;
`else
  logic unused_dbg;

  assign unused_dbg = halt ^ step_req;
  assign adv        = 1'b1;
  assign step_done  = 1'b0;
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_nes_clk_en.sv
// Self-checking bench for nes_clk_en: cycle-count reference model plus
// directed cadence/halt/step/reset scenarios and a randomized halt/step soak.
module tb_nes_clk_en;
  localparam int D = 4;
  localparam int R = 3;
  localparam int P = D * R;
  localparam int CNT_W = 32;
`ifdef NES_CLK_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

  logic clk = 1'b0, rst_n = 1'b0, halt = 1'b0, step_req = 1'b0;
  logic ppu_ce, cpu_ce, apu_ce, halted, step_done;
  logic [CNT_W-1:0] cpu_cycles;

  nes_clk_en #(.PPU_DIV(D), .CPU_RATIO(R), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .step_req(step_req),
    .ppu_ce(ppu_ce), .cpu_ce(cpu_ce), .apu_ce(apu_ce), .halted(halted),
    .step_done(step_done), .cpu_cycles(cpu_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // cyc = index of the cycle sampled by the next rising edge
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Reference model: number of advancing cycles since reset fixes every strobe.
  longint m_adv = 0, n_adv = 0;
  longint m_cpu = 0, n_cpu = 0;
  int     m_mode = M_RUN, n_mode = M_RUN;
  int ppu_q[$], cpu_q[$], apu_q[$], sd_q[$];

  always @(negedge clk) begin
    bit a, bnd, pe, ce, ae, sd;
    if (armed) begin
      if (!rst_n) begin
        chk("rst_ppu", ppu_ce, 0);   chk("rst_cpu", cpu_ce, 0);
        chk("rst_apu", apu_ce, 0);   chk("rst_halted", halted, 0);
        chk("rst_sd", step_done, 0); chk("rst_cyc", cpu_cycles, 0);
        n_adv = 0; n_cpu = 0; n_mode = M_RUN;
      end else begin
        bnd = (m_adv % P) == 0;
        a = 1'b1; sd = 1'b0; n_mode = m_mode;
        if (STEP_EN) begin
          case (m_mode)
            M_RUN:  if (halt && bnd) begin a = 1'b0; n_mode = M_HALT; end
            M_HALT: begin
              a = 1'b0;
              if (step_req) n_mode = M_STEP;
              else if (!halt) n_mode = M_RUN;
            end
            default: a = 1'b1;
          endcase
        end
        pe = a && (m_adv % D == D - 1);
        ce = a && (m_adv % P == P - 1);
        ae = a && (m_adv % (2 * P) == 2 * P - 1);
        if (STEP_EN && m_mode == M_STEP && ce) begin
          sd = 1'b1;
          n_mode = halt ? M_HALT : M_RUN;
        end
        chk("ppu_ce", ppu_ce, pe);
        chk("cpu_ce", cpu_ce, ce);
        chk("apu_ce", apu_ce, ae);
        chk("halted", halted, (STEP_EN && m_mode == M_HALT));
        chk("step_done", step_done, sd);
        chk("cpu_cycles", cpu_cycles, m_cpu[CNT_W-1:0]);
        n_adv = m_adv + a;
        n_cpu = m_cpu + ce;
        if (ppu_ce)    ppu_q.push_back(cyc);
        if (cpu_ce)    cpu_q.push_back(cyc);
        if (apu_ce)    apu_q.push_back(cyc);
        if (step_done) sd_q.push_back(cyc);
      end
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin m_adv <= 0; m_cpu <= 0; m_mode <= M_RUN; end
    else        begin m_adv <= n_adv; m_cpu <= n_cpu; m_mode <= n_mode; end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; halt = 1'b0; step_req = 1'b0;
    #1;
    chk("async_ppu", ppu_ce, 0);   chk("async_cpu", cpu_ce, 0);
    chk("async_apu", apu_ce, 0);   chk("async_halted", halted, 0);
    chk("async_sd", step_done, 0); chk("async_cyc", cpu_cycles, 0);
    ppu_q.delete(); cpu_q.delete(); apu_q.delete(); sd_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic chk_q(input string nm, input int q[$], input int exp[$]);
    chk({nm, "_n"}, q.size(), exp.size());
    foreach (exp[i]) if (i < q.size()) chk(nm, q[i], exp[i]);
  endtask

  int exp_q[$];

  initial begin
    #12 armed = 1'b1;

    // free-running cadence
    do_reset();
    wait_cyc(48);
    chk("cyc_at_48", cpu_cycles, 4);
    wait_cyc(49);
    chk("ppu_n", ppu_q.size(), 12);
    if (ppu_q.size() == 12) begin chk("ppu_first", ppu_q[0], 3); chk("ppu_last", ppu_q[11], 47); end
    exp_q = '{11, 23, 35, 47}; chk_q("cpu_at", cpu_q, exp_q);
    exp_q = '{23, 47};         chk_q("apu_at", apu_q, exp_q);

    // halt at cycle 5, then single step with halt held
    do_reset();
    wait_cyc(5); halt = 1'b1;
    if (STEP_EN) begin
      wait_cyc(12); chk("halted_12", halted, 0);
      wait_cyc(13); chk("halted_13", halted, 1);
      wait_cyc(20); chk("cyc_halted", cpu_cycles, 1);
      exp_q = '{11}; chk_q("cpu_pre_halt", cpu_q, exp_q);
      step_req = 1'b1;
      wait_cyc(21); step_req = 1'b0;
      wait_cyc(32); chk("halted_32", halted, 0);
      wait_cyc(33); chk("halted_33", halted, 1);
      chk("cyc_after_step", cpu_cycles, 2);
      wait_cyc(40);
      exp_q = '{32};     chk_q("sd_at", sd_q, exp_q);
      exp_q = '{11, 32}; chk_q("cpu_step", cpu_q, exp_q);
      exp_q = '{24, 28, 32};
      while (ppu_q.size() > 0 && ppu_q[0] < 21) void'(ppu_q.pop_front());
      chk_q("ppu_step", ppu_q, exp_q);
    end else begin
      wait_cyc(49);
      chk("cyc_at_48_nostep", cpu_cycles, 4);
      exp_q = '{11, 23, 35, 47}; chk_q("cpu_nostep", cpu_q, exp_q);
      exp_q = '{23, 47};         chk_q("apu_nostep", apu_q, exp_q);
      chk("sd_nostep_n", sd_q.size(), 0);
    end

    // step_req in RUN ignored; step with halt low in HALT returns to RUN
    do_reset();
    foreach (exp_q[i]) ;
    wait_cyc(4);  step_req = 1'b1; wait_cyc(5);  step_req = 1'b0;
    wait_cyc(11); step_req = 1'b1; wait_cyc(13); step_req = 1'b0;
    wait_cyc(14); halt = 1'b1;
    wait_cyc(30); halt = 1'b0; step_req = 1'b1;
    wait_cyc(31); step_req = 1'b0;
    wait_cyc(56);
    if (STEP_EN) begin
      exp_q = '{42};             chk_q("sd_run_ret", sd_q, exp_q);
      exp_q = '{11, 23, 42, 54}; chk_q("cpu_run_ret", cpu_q, exp_q);
      chk("halted_run_ret", halted, 0);
    end else begin
      exp_q = '{11, 23, 35, 47}; chk_q("cpu_run_nostep", cpu_q, exp_q);
    end

    // reset pulsed between edges in the middle of a step
    do_reset();
    wait_cyc(1);  halt = 1'b1;
    wait_cyc(15); step_req = 1'b1;
    wait_cyc(16); step_req = 1'b0;
    wait_cyc(20);
    do_reset();
    wait_cyc(30);
    chk("sd_after_rst_n", sd_q.size(), 0);
    exp_q = '{11, 23}; chk_q("cpu_after_rst", cpu_q, exp_q);

    // randomized halt/step soak
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) halt = ~halt;
      step_req = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    halt = 1'b0; step_req = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
